dmem_arbiter: RTL

//  Shares the single byte-addressed data memory port between two requesters: port 0 (core LSU) and port 1 (debug/DMA loader).

---
 rtl/dmem_pkg.sv | 37 +++
 rtl/rr_arb2.sv | 24 ++
 rtl/dmem_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter.
//   - RV32 load/store funct3 encodings
//   - arbiter FSM state encoding (2 bits)
//   - access_size(): bytes touched by a load/store funct3
package dmem_pkg;

    // Store encodings
    localparam logic [2:0] MEM_SB  = 3'b000;
    localparam logic [2:0] MEM_SH  = 3'b001;
    localparam logic [2:0] MEM_SW  = 3'b010;

    // Load encodings
    localparam logic [2:0] MEM_LB  = 3'b000;
    localparam logic [2:0] MEM_LH  = 3'b001;
    localparam logic [2:0] MEM_LW  = 3'b010;
    localparam logic [2:0] MEM_LBU = 3'b100;
    localparam logic [2:0] MEM_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } dmem_state_e;

    // Bytes touched by an access; funct3[2] only selects sign/zero extension.
    // The 2'b11 encoding is illegal for every access and is rejected separately.
    function automatic logic [2:0] access_size(input logic [2:0] funct3);
        logic [2:0] size;
        case (funct3[1:0])
            2'b00:   size = 3'd1;
            2'b01:   size = 3'd2;
            default: size = 3'd4;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker, purely combinational.
//   valid      in   2  request lines of port 0 and port 1
//   last_grant in   1  port granted by the previous transaction
//   grant      out  1  selected port (meaningful only when any=1)
//   any        out  1  at least one port is requesting
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       grant,
    output logic       any
);

    always_comb begin
        any   = |valid;
        grant = 1'b0;
        case (valid)
            2'b10:   grant = 1'b1;
            // Contention: the port that did not win last time goes next.
            2'b11:   grant = ~last_grant;
            default: grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single byte-addressed data-memory port between the core LSU (port 0)
// and the debug/DMA loader (port 1). One transaction in flight, three cycles each:
// IDLE (accept) -> ACCESS (memory pins driven) -> RESP (one-cycle response pulse).
// Illegal funct3, out-of-range and (optionally) misaligned requests never reach
// the memory; they are answered with resp_err=1 and resp_rdata=0.
//
// Optional build macro: DMEM_ARB_ALIGN_CHECK_EN
//   defined   - halfword accesses with addr[0]!=0 and word accesses with
//               addr[1:0]!=0 are rejected as errors
//   undefined - misaligned accesses are passed through to the byte-wise memory
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   req_valid[i]    requester i has a request, held stable until req_ready[i]
//   req_ready[i]    request i accepted this cycle (combinational, IDLE only)
//   req_we[i]       1=store, 0=load
//   req_addr[i]     byte address
//   req_wdata[i]    store data
//   req_funct3[i]   RV32 load/store funct3
//   resp_valid[i]   one-cycle response pulse for requester i
//   resp_rdata      load data (0 for stores and errors)
//   resp_err        request rejected
//   mem_*           data-memory interface; mem_rdata is a combinational read
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0]             req_we,
    input  logic [1:0][ADDR_W-1:0] req_addr,
    input  logic [1:0][31:0]       req_wdata,
    input  logic [1:0][2:0]        req_funct3,

    output logic [1:0]             resp_valid,
    output logic [31:0]            resp_rdata,
    output logic                   resp_err,

    output logic                   mem_read,
    output logic                   mem_write,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [31:0]            mem_wdata,
    output logic [2:0]             mem_funct3,
    input  logic [31:0]            mem_rdata
);

    // One extra bit so that addr + size cannot wrap around at the top of the space.
    localparam int unsigned EXT_W = ADDR_W + 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    dmem_state_e        state_q;
    logic               last_grant_q;
    logic               grant_q;
    logic               we_q;
    logic               err_q;

    logic               mem_read_q;
    logic               mem_write_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [31:0]        mem_wdata_q;
    logic [2:0]         mem_funct3_q;

    logic [1:0]         resp_valid_q;
    logic [31:0]        resp_rdata_q;
    logic               resp_err_q;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic arb_grant;
    logic arb_any;

    rr_arb2 u_rr_arb2 (
        .valid      (req_valid),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .any        (arb_any)
    );

    // Fields of the request that would be accepted this cycle
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic [2:0]        sel_funct3;

    always_comb begin
        sel_we     = req_we[arb_grant];
        sel_addr   = req_addr[arb_grant];
        sel_wdata  = req_wdata[arb_grant];
        sel_funct3 = req_funct3[arb_grant];
    end

    // ------------------------------------------------------------------
    // Legality check of the selected request
    // ------------------------------------------------------------------
    logic [2:0]       sel_size;
    logic [EXT_W-1:0] sel_end;
    logic             funct3_err;
    logic             range_err;
    logic             align_err;
    logic             sel_err;

    always_comb begin
        sel_size  = access_size(sel_funct3);
        sel_end   = {1'b0, sel_addr} + EXT_W'(sel_size);
        range_err = sel_end > EXT_W'(MEM_BYTES);

        funct3_err = 1'b1;
        if (sel_we) begin
            case (sel_funct3)
                MEM_SB, MEM_SH, MEM_SW: funct3_err = 1'b0;
                default:                funct3_err = 1'b1;
            endcase
        end else begin
            case (sel_funct3)
                MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU: funct3_err = 1'b0;
                default:                                  funct3_err = 1'b1;
            endcase
        end

`ifdef DMEM_ARB_ALIGN_CHECK_EN
        align_err = ((sel_size == 3'd2) && sel_addr[0]) ||
                    ((sel_size == 3'd4) && (sel_addr[1:0] != 2'b00));
`else
        align_err = 1'b0;
`endif

        sel_err = funct3_err || range_err || align_err;
    end

    // ------------------------------------------------------------------
    // Handshake: ready only in IDLE, only to the winning port
    // ------------------------------------------------------------------
    always_comb begin
        req_ready = 2'b00;
        if ((state_q == ST_IDLE) && arb_any) begin
            req_ready[arb_grant] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FSM with registered memory and response outputs. The async reset clears
    // mem_write immediately, so a store caught in ACCESS is never committed.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_funct3_q <= '0;
            resp_valid_q <= 2'b00;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arb_any) begin
                        grant_q     <= arb_grant;
                        we_q        <= sel_we;
                        err_q       <= sel_err;
                        mem_read_q  <= !sel_err && !sel_we;
                        mem_write_q <= !sel_err && sel_we;
                        // Rejected requests leave the memory pins quiet.
                        if (!sel_err) begin
                            mem_addr_q   <= sel_addr;
                            mem_wdata_q  <= sel_wdata;
                            mem_funct3_q <= sel_funct3;
                        end
                        state_q     <= ST_ACCESS;
                    end
                end

                ST_ACCESS: begin
                    mem_read_q   <= 1'b0;
                    mem_write_q  <= 1'b0;
                    mem_addr_q   <= '0;
                    mem_wdata_q  <= '0;
                    mem_funct3_q <= '0;
                    resp_valid_q <= grant_q ? 2'b10 : 2'b01;
                    resp_err_q   <= err_q;
                    resp_rdata_q <= (!err_q && !we_q) ? mem_rdata : 32'h0;
                    state_q      <= ST_RESP;
                end

                ST_RESP: begin
                    resp_valid_q <= 2'b00;
                    resp_rdata_q <= '0;
                    resp_err_q   <= 1'b0;
                    last_grant_q <= grant_q;
                    state_q      <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_funct3 = mem_funct3_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule
